// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target with a byte-addressed register file, a host preload/readback port
// and a one-cycle strobe for every byte committed by a bus write.
//
// state       | meaning
// IDLE        | bus ignored until START
// ADDR        | shifting 7-bit address + R/W
// ADDR_ACK    | driving ACK for a matching address
// PTR         | shifting register pointer byte
// PTR_ACK     | driving ACK for the pointer byte
// WDATA       | shifting a write data byte
// WDATA_ACK   | driving ACK; byte commits on its closing SCL fall
// RDATA       | driving register[ptr] MSB first
// RACK        | SDA released, sampling initiator ACK/NACK
// WAIT_STOP   | not addressed or NACKed; wait for STOP or START
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h38,
    parameter int         NUM_REGS = 16,
    localparam int        AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT_STOP
    } state_t;

    logic [1:0]    rst_sync;
    logic          rst_i;
    logic [1:0]    scl_sync, sda_sync;
    logic [2:0]    scl_hist, sda_hist;
    logic          scl_f, sda_f, scl_q, sda_q;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t        state, state_d;
    logic [3:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shift, shift_d, tx, tx_d;
    logic [AW-1:0] ptr, ptr_d, ptr_inc;
    logic          rw, rw_d, oe_d, busy_d, strobe_d;
    logic [AW-1:0] waddr_d;
    logic [7:0]    wdata_d;
    logic [7:0]    mem [NUM_REGS];

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= '0;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Idle bus is high, so the conditioning chain resets high to avoid false edges.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync <= '1; sda_sync <= '1;
            scl_hist <= '1; sda_hist <= '1;
            scl_f    <= 1'b1; sda_f <= 1'b1;
            scl_q    <= 1'b1; sda_q <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            scl_f    <= maj3(scl_hist);
            sda_f    <= maj3(sda_hist);
            scl_q    <= scl_f;
            sda_q    <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign ptr_inc   = ptr + AW'(1);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tx        <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            tx        <= tx_d;
            ptr       <= ptr_d;
            rw        <= rw_d;
            sda_oe    <= oe_d;
            busy      <= busy_d;
            wr_strobe <= strobe_d;
            wr_addr   <= waddr_d;
            wr_data   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        tx_d      = tx;
        ptr_d     = ptr;
        rw_d      = rw;
        oe_d      = sda_oe;
        busy_d    = busy;
        strobe_d  = 1'b0;
        waddr_d   = wr_addr;
        wdata_d   = wr_data;
        if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else if (scl_rise) begin
            if (state inside {S_ADDR, S_PTR, S_WDATA, S_RDATA, S_RACK}) begin
                shift_d   = {shift[6:0], sda_f};
                bit_cnt_d = bit_cnt + 4'd1;
            end
        end else if (scl_fall) begin
            case (state)
                S_ADDR: if (bit_cnt == 4'd8) begin
                    if (shift[7:1] == DEV_ADDR) begin
                        state_d = S_ADDR_ACK;
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        rw_d    = shift[0];
                    end else begin
                        state_d = S_WAIT_STOP;
                        oe_d    = 1'b0;
                    end
                end
                S_ADDR_ACK: begin
                    bit_cnt_d = '0;
                    if (rw) begin
                        state_d = S_RDATA;
                        tx_d    = mem[ptr];
                        oe_d    = ~mem[ptr][7];
                    end else begin
                        state_d = S_PTR;
                        oe_d    = 1'b0;
                    end
                end
                S_PTR: if (bit_cnt == 4'd8) begin
                    ptr_d   = shift[AW-1:0];
                    state_d = S_PTR_ACK;
                    oe_d    = 1'b1;
                end
                S_PTR_ACK: begin
                    state_d   = S_WDATA;
                    bit_cnt_d = '0;
                    oe_d      = 1'b0;
                end
                S_WDATA: if (bit_cnt == 4'd8) begin
                    state_d = S_WDATA_ACK;
                    oe_d    = 1'b1;
                end
                S_WDATA_ACK: begin
                    strobe_d  = 1'b1;
                    waddr_d   = ptr;
                    wdata_d   = shift;
                    ptr_d     = ptr_inc;
                    state_d   = S_WDATA;
                    bit_cnt_d = '0;
                    oe_d      = 1'b0;
                end
                S_RDATA: if (bit_cnt == 4'd8) begin
                    state_d = S_RACK;
                    oe_d    = 1'b0;
                end else begin
                    tx_d = {tx[6:0], tx[7]};
                    oe_d = ~tx[6];
                end
                S_RACK: if (!shift[0]) begin
                    ptr_d     = ptr_inc;
                    tx_d      = mem[ptr_inc];
                    oe_d      = ~mem[ptr_inc][7];
                    bit_cnt_d = '0;
                    state_d   = S_RDATA;
                end else begin
                    state_d = S_WAIT_STOP;
                    oe_d    = 1'b0;
                end
                default: ;
            endcase
        end
        if (state_d == S_IDLE || state_d == S_WAIT_STOP) busy_d = 1'b0;
    end

    // The bus write lands after the host write so it wins on a shared index.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            host_rdata <= '0;
        end else begin
            if (host_we)   mem[host_addr] <= host_wdata;
            if (wr_strobe) mem[wr_addr]   <= wr_data;
            host_rdata <= mem[host_addr];
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Bench for i2c_target_regs: bit-banged I2C initiator on an open-drain bus model,
// with scoreboard queues for committed bus writes and returned read bytes.
module tb_i2c_target_regs;

    localparam int Q = 10;  // clk cycles per SCL quarter period

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_in, sda_in, sda_oe, sda_line;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    logic [11:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int   n_cmp = 0, n_bad = 0, strobe_cnt = 0;
    logic oe_seen = 1'b0, busy_seen = 1'b0, strobe_prev = 1'b0;

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;
    assign scl_in   = scl_m;
    assign sda_in   = sda_line;

    i2c_target_regs #(.DEV_ADDR(7'h38), .NUM_REGS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] e;
        if (sda_oe) oe_seen = 1'b1;
        if (busy)   busy_seen = 1'b1;
        if (wr_strobe) begin
            strobe_cnt++;
            chk("strobe_width", 32'(strobe_prev), 0);
            chk("strobe_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[11:8]));
                chk("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
        strobe_prev = wr_strobe;
    end

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b;    qwait();
        scl_m = 1'b1; qwait();
        s = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        logic ack;
        write_byte(b, ack);
        chk($sformatf("ack_%02h", b), 32'(ack), 1);
    endtask

    task automatic rd_expect(input logic nack);
        logic [7:0] d;
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
        chk("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) chk("rd_data", 32'(d), 32'(exp_rd.pop_front()));
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] v);
        host_addr = a; host_wdata = v; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] v);
        host_addr = a;
        repeat (2) @(negedge clk);
        v = host_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       ack, s;
        int         n0;

        repeat (4) @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_wr_strobe", 32'(wr_strobe), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_host_rdata", 32'(host_rdata), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        host_read(4'd3, d); chk("rst_reg3", 32'(d), 0);

        // write burst
        bus_start();
        wr_byte(8'h70);
        chk("burst_busy", 32'(busy), 1);
        wr_byte(8'h02);
        exp_wr.push_back({4'd2, 8'hA5}); wr_byte(8'hA5);
        exp_wr.push_back({4'd3, 8'h5A}); wr_byte(8'h5A);
        bus_stop(); qwait();
        chk("burst_busy_end", 32'(busy), 0);
        host_read(4'd3, d); chk("burst_reg3", 32'(d), 'h5A);
        host_read(4'd2, d); chk("burst_reg2", 32'(d), 'hA5);

        // combined read with repeated START
        host_write(4'd5, 8'h3C);
        host_write(4'd6, 8'hC3);
        bus_start(); wr_byte(8'h70); wr_byte(8'h05);
        bus_start(); wr_byte(8'h71);
        exp_rd.push_back(8'h3C); rd_expect(1'b0);
        exp_rd.push_back(8'hC3); rd_expect(1'b1);
        chk("nack_release", 32'(sda_oe), 0);
        bus_stop(); qwait();

        // wrong address
        oe_seen = 1'b0; busy_seen = 1'b0; n0 = strobe_cnt;
        bus_start();
        write_byte(8'h72, ack); chk("wrong_addr_nack", 32'(ack), 0);
        write_byte(8'h00, ack); chk("wrong_data_nack", 32'(ack), 0);
        bus_stop(); qwait();
        chk("wrong_oe_seen", 32'(oe_seen), 0);
        chk("wrong_busy_seen", 32'(busy_seen), 0);
        chk("wrong_strobes", 32'(strobe_cnt - n0), 0);

        // pointer wrap and ignored upper pointer bits
        bus_start(); wr_byte(8'h70); wr_byte(8'h0F);
        exp_wr.push_back({4'd15, 8'h11}); wr_byte(8'h11);
        exp_wr.push_back({4'd0, 8'h22});  wr_byte(8'h22);
        bus_stop(); qwait();
        host_read(4'd15, d); chk("wrap_reg15", 32'(d), 'h11);
        host_read(4'd0, d);  chk("wrap_reg0", 32'(d), 'h22);
        bus_start(); wr_byte(8'h70); wr_byte(8'h1F);
        exp_wr.push_back({4'd15, 8'h33}); wr_byte(8'h33);
        bus_stop(); qwait();
        host_read(4'd15, d); chk("ptr_upper_ignored", 32'(d), 'h33);

        // STOP inside a data byte
        n0 = strobe_cnt;
        bus_start(); wr_byte(8'h70); wr_byte(8'h07);
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
        bus_stop(); qwait();
        chk("abort_strobes", 32'(strobe_cnt - n0), 0);
        host_read(4'd7, d); chk("abort_reg7", 32'(d), 0);

        // pointer-only write, then reset while driving a read bit low
        host_write(4'd4, 8'h12);
        bus_start(); wr_byte(8'h70); wr_byte(8'h04); bus_stop();
        bus_start(); wr_byte(8'h71);
        chk("read_oe_driving", 32'(sda_oe), 1);
        #2 rst = 1'b0;
        #1 chk("reset_oe_async", 32'(sda_oe), 0);
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        oe_seen = 1'b0; n0 = strobe_cnt;
        bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
        bus_stop(); qwait();
        chk("post_reset_ignore_oe", 32'(oe_seen), 0);
        chk("post_reset_ignore_strobe", 32'(strobe_cnt - n0), 0);
        host_read(4'd4, d); chk("reset_clears_reg4", 32'(d), 0);
        bus_start(); wr_byte(8'h70); wr_byte(8'h09);
        exp_wr.push_back({4'd9, 8'h77}); wr_byte(8'h77);
        bus_stop();
        bus_start(); wr_byte(8'h70); wr_byte(8'h09);
        bus_start(); wr_byte(8'h71);
        exp_rd.push_back(8'h77); rd_expect(1'b1);
        bus_stop(); qwait();

        // host write in the same cycle as a bus commit
        fork
            begin
                int n;
                for (int k = 0; k < 2; k++) begin
                    n = 0;
                    while (!wr_strobe && n < 4000) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("coll_strobe_seen", 32'(wr_strobe), 1);
                    host_addr  = (k == 0) ? 4'd2 : 4'd10;
                    host_wdata = (k == 0) ? 8'h44 : 8'h55;
                    host_we    = 1'b1;
                    @(negedge clk);
                    host_we = 1'b0;
                    repeat (2) @(negedge clk);
                end
            end
            begin
                bus_start(); wr_byte(8'h70); wr_byte(8'h02);
                exp_wr.push_back({4'd2, 8'h99}); wr_byte(8'h99);
                exp_wr.push_back({4'd3, 8'h66}); wr_byte(8'h66);
                bus_stop();
            end
        join
        qwait();
        host_read(4'd2, d);  chk("coll_bus_wins", 32'(d), 'h99);
        host_read(4'd3, d);  chk("coll_reg3", 32'(d), 'h66);
        host_read(4'd10, d); chk("coll_host_other", 32'(d), 'h55);

        chk("wr_queue_drained", 32'(exp_wr.size()), 0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
